key_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the multiplier top level. It takes the raw active-low pushbuttons and slide switches from the board and synchronises every input. Each key is debounced through a per-key state machine, and each clean press is delivered as a single-cycle active-high pulse. A busy interlock holds a press until the downstream FSM can accept it. The multiplier's Run/Reset button handling and switch synchronisers consume these outputs instead of raw board pins.

---
 rtl/key_cond_pkg.sv | 21 ++
 rtl/key_debounce.sv | 143 ++++++++++++++
 rtl/key_conditioner.sv | 62 ++++++
 tb/tb_key_conditioner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// key_cond_pkg
//   Shared types and constants for the key conditioning stage.
//   key_state_t : per-key debounce FSM state encoding
//   SYNC_STAGES : depth of every input synchroniser chain
package key_cond_pkg;

  // state        | meaning
  // RELEASED     | key stable released, level 0
  // PRESS_WAIT   | pressed seen, counting stable pressed cycles
  // HELD         | key accepted as pressed, level 1
  // RELEASE_WAIT | released seen, counting stable released cycles
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   One pushbutton: synchroniser, debounce FSM with saturating counter,
//   press-pulse generation with busy interlock and sticky overrun flag.
//   clk_i       : system clock, rising edge
//   rst_i       : asynchronous active-high reset
//   key_n_i     : raw active-low key, asynchronous
//   busy_i      : downstream busy; holds a press pending while high
//   level_o     : debounced level, 1 = pressed
//   press_o     : single-cycle pulse per accepted press
//   overrun_o   : sticky, set when a press merges into a pending one
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  input  logic busy_i,
  output logic level_o,
  output logic press_o,
  output logic overrun_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  key_state_t             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   press_evt_q;
  logic                   pending_q, pending_d;
  logic                   press_q, press_d;
  logic                   overrun_q, overrun_d;

  // The inversion sits in front of the chain so the reset value 0 of
  // every synchroniser flop reads as "released"; a raw-polarity chain
  // reset to 0 would look like a press for the first cycles after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ~key_n_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM; level and the press event are registered with the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_evt_q <= 1'b0;
    end else begin
      press_evt_q <= 1'b0;
      unique case (state_q)
        RELEASED: begin
          if (s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q     <= HELD;
            cnt_q       <= '0;
            level_q     <= 1'b1;
            press_evt_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            // Bounce during release: back to held, no new press event.
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // A new press and a pending one are merged into one request; it goes
  // out when busy is low. The press_q guard keeps pulses non-adjacent.
  always_comb begin
    press_d   = 1'b0;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (press_evt_q && pending_q) begin
      overrun_d = 1'b1;
    end
    if (press_evt_q || pending_q) begin
      if (!busy_i && !press_q) begin
        press_d   = 1'b1;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      press_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      press_q   <= press_d;
      overrun_q <= overrun_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
//   Board input conditioning ahead of the multiplier top level.
//   Clk         : system clock, rising edge
//   Reset       : asynchronous active-high reset
//   Key_n       : raw active-low pushbuttons (bit 0 Run_Accumulate,
//                 bit 1 Reset_Clear)
//   SW          : raw slide switches
//   Busy        : per-key downstream busy, holds presses pending
//   Key_level   : debounced key levels, 1 = pressed
//   Key_press   : one-cycle pulse per accepted press
//   Key_overrun : sticky per-key overrun flags
//   SW_sync     : synchronised switches (not debounced)
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned SW_WIDTH        = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_KEYS-1:0]   Key_n,
  input  logic [SW_WIDTH-1:0] SW,
  input  logic [N_KEYS-1:0]   Busy,
  output logic [N_KEYS-1:0]   Key_level,
  output logic [N_KEYS-1:0]   Key_press,
  output logic [N_KEYS-1:0]   Key_overrun,
  output logic [SW_WIDTH-1:0] SW_sync
);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk_i    (Clk),
      .rst_i    (Reset),
      .key_n_i  (Key_n[k]),
      .busy_i   (Busy[k]),
      .level_o  (Key_level[k]),
      .press_o  (Key_press[k]),
      .overrun_o(Key_overrun[k])
    );
  end

  logic [SW_WIDTH-1:0] sw_pipe_q [SYNC_STAGES];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_pipe_q[i] <= '0;
      end
    end else begin
      sw_pipe_q[0] <= SW;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_pipe_q[i] <= sw_pipe_q[i-1];
      end
    end
  end

  assign SW_sync = sw_pipe_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int DEB = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Key_n, Busy, Key_level, Key_press, Key_overrun;
  logic [7:0] SW, SW_sync;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .N_KEYS(2),
    .SW_WIDTH(8)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Key_n      (Key_n),
    .SW         (SW),
    .Busy       (Busy),
    .Key_level  (Key_level),
    .Key_press  (Key_press),
    .Key_overrun(Key_overrun),
    .SW_sync    (SW_sync)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   {30'd0, Key_level},   32'd0);
    chk({tag, "_press"},   {30'd0, Key_press},   32'd0);
    chk({tag, "_overrun"}, {30'd0, Key_overrun}, 32'd0);
    chk({tag, "_sw"},      {24'd0, SW_sync},     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    Key_n = 2'b11;
    Busy  = 2'b00;
    SW    = 8'h00;
    #1;
    chk_all_zero("reset");
    step();
    step();
    chk_all_zero("reset_held");
    Reset = 1'b0;
    repeat (3) step();
    chk_all_zero("idle");

    // Clean press: level after edge 6, single pulse after edge 7.
    Key_n[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("clean_level", Key_level[0], k >= 6);
      chk("clean_press", Key_press[0], k == 7);
    end
    Key_n[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("release_level", Key_level[0], k < 6);
      chk("release_press", Key_press[0], 0);
    end

    // Bounce: low/high every 2 cycles never reaches the 4-cycle threshold.
    for (int k = 0; k < 16; k++) begin
      Key_n[0] = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      chk("bounce_level", Key_level[0], 0);
      chk("bounce_press", Key_press[0], 0);
    end
    Key_n[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("bounce_tail_level", Key_level[0], 0);
      chk("bounce_tail_press", Key_press[0], 0);
    end

    // Busy interlock on key 1.
    Busy[1]  = 1'b1;
    Key_n[1] = 1'b0;
    for (int k = 0; k < 18; k++) begin
      step();
      chk("busy_level", Key_level[1], k >= 6);
      chk("busy_press_held", Key_press[1], 0);
    end
    Busy[1] = 1'b0;
    for (int m = 0; m < 5; m++) begin
      step();
      chk("busy_release_press", Key_press[1], m == 0);
    end
    Key_n[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("busy_keyrel_press", Key_press[1], 0);
    end
    chk("busy_overrun", Key_overrun[1], 0);
    chk("busy_level_end", Key_level[1], 0);

    // Overrun on key 0.
    Busy[0]  = 1'b1;
    Key_n[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("ovr_press1", Key_press[0], 0);
    end
    Key_n[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("ovr_rel_press", Key_press[0], 0);
    end
    chk("ovr_not_yet", Key_overrun[0], 0);
    Key_n[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("ovr_press2", Key_press[0], 0);
    end
    chk("ovr_flag", Key_overrun[0], 1);
    chk("ovr_level", Key_level[0], 1);
    Busy[0] = 1'b0;
    pulses  = 0;
    for (int m = 0; m < 6; m++) begin
      step();
      chk("ovr_deliver", Key_press[0], m == 0);
      if (Key_press[0]) pulses++;
    end
    chk("ovr_pulse_count", pulses, 1);
    Key_n[0] = 1'b1;
    repeat (10) step();
    chk("ovr_sticky", Key_overrun[0], 1);
    Reset = 1'b1;
    #1;
    chk_all_zero("ovr_reset");
    step();
    Reset = 1'b0;
    repeat (2) step();
    chk("ovr_after_reset", Key_overrun[0], 0);

    // Reset two cycles into PRESS_WAIT with the key held throughout.
    Key_n[0] = 1'b0;
    repeat (4) step();
    Reset = 1'b1;
    #1;
    chk_all_zero("middeb_reset");
    step();
    step();
    chk_all_zero("middeb_reset_held");
    Reset = 1'b0;
    for (int k = 0; k < 13; k++) begin
      step();
      chk("middeb_press", Key_press[0], k == 7);
      chk("middeb_level", Key_level[0], k >= 6);
    end
    Key_n[0] = 1'b1;
    repeat (10) step();
    chk("middeb_released", Key_level[0], 0);

    // Busy drops in the same cycle as the press event.
    Busy[0]  = 1'b1;
    Key_n[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("bfall_level", Key_level[0], k >= 6);
      chk("bfall_press_early", Key_press[0], 0);
    end
    Busy[0] = 1'b0;
    step();
    chk("bfall_press", Key_press[0], 1);
    step();
    chk("bfall_press_off", Key_press[0], 0);
    chk("bfall_overrun", Key_overrun[0], 0);
    Key_n[0] = 1'b1;
    repeat (10) step();

    // Switch path.
    SW = 8'hA5;
    step();
    chk("sw_edge0", SW_sync, 8'h00);
    step();
    chk("sw_edge1", SW_sync, 8'hA5);
    chk("sw_keys", Key_press, 2'b00);
    SW = 8'h3C;
    step();
    step();
    chk("sw_second", SW_sync, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
